multicast_expander: RTL

Parametrised, registered successor to the combinational multi-packet target generator. It accepts one packet per handshake and, when any fault node is enabled, expands column (01), row (10) or broadcast (11) packets into a stream of unicast copies, skipping faulty nodes. With no fault enabled it passes the packet through unchanged. It sits between the local injection buffer (IBUF_A side) and the router input, and replaces the hijack-on-faulty-target scheme with in-block skipping plus drop accounting.

---
 rtl/multicast_expander.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/multicast_expander.sv
// multicast_expander: registered multicast-to-unicast expander with fault-node skipping and drop accounting
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_vld/in_rdy              input handshake; in_type/in_tgt/in_data packet fields
//   pg_en/pg_node              per-slot fault enable and {y,x} fault coordinates
//   out_vld/out_rdy            output handshake; out_type/out_tgt/out_data beat fields
//   out_cpy/out_last           beat is an expansion copy / carries the final candidate or a pass-through
//   burst_done                 one-cycle pulse when an expansion finishes
//   drop_cnt                   saturating count of discarded targets
module multicast_expander #(
    parameter int MESH_X     = 8,
    parameter int MESH_Y     = 8,
    parameter int NUM_PG     = 2,
    parameter int DATA_W     = 32,
    parameter int SKIP_LOCAL = 0,
    parameter int LOCAL_X    = 0,
    parameter int LOCAL_Y    = 0,
    localparam int XW = $clog2(MESH_X),
    localparam int YW = $clog2(MESH_Y),
    localparam int TW = XW + YW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [1:0]           in_type,
    input  logic [TW-1:0]        in_tgt,
    input  logic [DATA_W-1:0]    in_data,
    input  logic [NUM_PG-1:0]    pg_en,
    input  logic [NUM_PG*TW-1:0] pg_node,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [1:0]           out_type,
    output logic [TW-1:0]        out_tgt,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_cpy,
    output logic                 out_last,
    output logic                 burst_done,
    output logic [7:0]           drop_cnt
);
    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [XW-1:0] X_MAX     = XW'(MESH_X - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(MESH_Y - 1);
    localparam logic [XW-1:0] X_ONE     = XW'(1);
    localparam logic [YW-1:0] Y_ONE     = YW'(1);
    localparam logic [TW-1:0] LOCAL_TGT = {YW'(LOCAL_Y), XW'(LOCAL_X)};

    state_t                state_q, state_d;
    logic [1:0]            typ_q, typ_d;
    logic [TW-1:0]         cand_q, cand_d;
    logic [DATA_W-1:0]     dat_q, dat_d;
    logic [NUM_PG-1:0]     pen_q, pen_d;
    logic [NUM_PG*TW-1:0]  pnode_q, pnode_d;
    logic                  out_vld_q, out_vld_d;
    logic [1:0]            out_type_q, out_type_d;
    logic [TW-1:0]         out_tgt_q, out_tgt_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;
    logic                  out_cpy_q, out_cpy_d;
    logic                  out_last_q, out_last_d;
    logic                  burst_done_q, burst_done_d;
    logic [7:0]            drop_q, drop_d;

    logic                  slot_free, accept, expand_go, in_hit, cand_hit, cand_local;
    logic                  drop_inc, x_end, y_end, is_final;
    logic [XW-1:0]         cx;
    logic [YW-1:0]         cy;
    logic [TW-1:0]         first_cand, cand_next;

    function automatic logic hit(input logic [NUM_PG-1:0] en, input logic [NUM_PG*TW-1:0] nodes,
                                 input logic [TW-1:0] t);
        hit = 1'b0;
        for (int i = 0; i < NUM_PG; i++)
            if (en[i] && nodes[i*TW +: TW] == t) hit = 1'b1;
    endfunction

    assign slot_free  = !out_vld_q || out_rdy;
    assign in_rdy     = (state_q == IDLE) && slot_free;
    assign accept     = in_vld && in_rdy;
    assign expand_go  = (in_type != 2'b00) && (pg_en != '0);
    assign in_hit     = hit(pg_en, pg_node, in_tgt);
    // expansion decisions use the fault set captured at accept, not the live inputs
    assign cand_hit   = hit(pen_q, pnode_q, cand_q);
    assign cand_local = (SKIP_LOCAL != 0) && (cand_q == LOCAL_TGT);

    assign cx    = cand_q[XW-1:0];
    assign cy    = cand_q[TW-1:XW];
    assign x_end = cx == X_MAX;
    assign y_end = cy == Y_MAX;

    assign is_final   = typ_q == 2'b01 ? y_end :
                        typ_q == 2'b10 ? x_end : (x_end && y_end);
    // broadcast walks row-major with x fastest; x wraps at MESH_X-1 so out-of-mesh values never appear
    assign cand_next  = typ_q == 2'b01 ? {cy + Y_ONE, cx} :
                        typ_q == 2'b10 ? {cy, cx + X_ONE} :
                        x_end          ? {cy + Y_ONE, {XW{1'b0}}} : {cy, cx + X_ONE};
    assign first_cand = in_type == 2'b01 ? {{YW{1'b0}}, in_tgt[XW-1:0]} :
                        in_type == 2'b10 ? {in_tgt[TW-1:XW], {XW{1'b0}}} : '0;

    always_comb begin
        state_d      = state_q;
        typ_d        = typ_q;
        cand_d       = cand_q;
        dat_d        = dat_q;
        pen_d        = pen_q;
        pnode_d      = pnode_q;
        out_vld_d    = out_vld_q && !out_rdy;
        out_type_d   = out_type_q;
        out_tgt_d    = out_tgt_q;
        out_data_d   = out_data_q;
        out_cpy_d    = out_cpy_q;
        out_last_d   = out_last_q;
        burst_done_d = 1'b0;
        drop_inc     = 1'b0;
        if (state_q == IDLE) begin
            if (accept) begin
                typ_d   = in_type;
                cand_d  = first_cand;
                dat_d   = in_data;
                pen_d   = pg_en;
                pnode_d = pg_node;
                if (expand_go) begin
                    state_d = EXPAND;
                end else if (in_type == 2'b00 && in_hit) begin
                    drop_inc = 1'b1;
                end else begin
                    out_vld_d  = 1'b1;
                    out_type_d = in_type;
                    out_tgt_d  = in_tgt;
                    out_data_d = in_data;
                    out_cpy_d  = 1'b0;
                    out_last_d = 1'b1;
                end
            end
        end else if (slot_free) begin
            if (cand_hit) begin
                drop_inc = 1'b1;
            end else if (!cand_local) begin
                out_vld_d  = 1'b1;
                out_type_d = 2'b00;
                out_tgt_d  = cand_q;
                out_data_d = dat_q;
                out_cpy_d  = 1'b1;
                out_last_d = is_final;
            end
            if (is_final) begin
                state_d      = IDLE;
                burst_done_d = 1'b1;
            end else begin
                cand_d = cand_next;
            end
        end
        drop_d = drop_q + {7'd0, drop_inc && (drop_q != 8'hFF)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            typ_q        <= '0;
            cand_q       <= '0;
            dat_q        <= '0;
            pen_q        <= '0;
            pnode_q      <= '0;
            out_vld_q    <= 1'b0;
            out_type_q   <= '0;
            out_tgt_q    <= '0;
            out_data_q   <= '0;
            out_cpy_q    <= 1'b0;
            out_last_q   <= 1'b0;
            burst_done_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            typ_q        <= typ_d;
            cand_q       <= cand_d;
            dat_q        <= dat_d;
            pen_q        <= pen_d;
            pnode_q      <= pnode_d;
            out_vld_q    <= out_vld_d;
            out_type_q   <= out_type_d;
            out_tgt_q    <= out_tgt_d;
            out_data_q   <= out_data_d;
            out_cpy_q    <= out_cpy_d;
            out_last_q   <= out_last_d;
            burst_done_q <= burst_done_d;
            drop_q       <= drop_d;
        end
    end

    assign out_vld    = out_vld_q;
    assign out_type   = out_type_q;
    assign out_tgt    = out_tgt_q;
    assign out_data   = out_data_q;
    assign out_cpy    = out_cpy_q;
    assign out_last   = out_last_q;
    assign burst_done = burst_done_q;
    assign drop_cnt   = drop_q;
endmodule
